tl45_scoreboard: RTL and testbench

Register scoreboard and issue controller for the TL45 register-read stage. Tracks outstanding writes to r1–r15 with per-register pending counters and drives the DPRF busy list. Decides each cycle whether the instruction at register read may issue, taking the operand-forwarding buses into account. Releases pending writes on writeback or when an in-flight instruction is killed by a flush.

---
 rtl/tl45_pkg.sv | 11 +
 rtl/tl45_scoreboard_if.sv | 41 ++++
 rtl/tl45_sb_counter.sv | 35 +++
 rtl/tl45_scoreboard.sv | 87 ++++++++
 tb/tb_tl45_scoreboard.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/tl45_pkg.sv
// Shared TL45 types and constants: register count, pending-counter width,
// and the 4-bit register index type.
package tl45_pkg;
   localparam int TL45_NREGS = 15;
   localparam int TL45_CNT_W = 2;

   typedef logic [3:0]            reg_idx_t;
   typedef logic [TL45_CNT_W-1:0] pend_cnt_t;

   localparam pend_cnt_t TL45_CNT_MAX = '1;
endpackage

// File: rtl/tl45_scoreboard_if.sv
// Register-read stage <-> scoreboard bundle. The pipeline side (master)
// drives the instruction, forwarding tags, writeback and kill. The
// scoreboard side (slave) answers with the issue decision and status.
interface tl45_scoreboard_if;
   import tl45_pkg::*;

   logic        i_issue_valid;
   logic        i_issue_wr;
   logic        i_ri;
   reg_idx_t    i_dr;
   reg_idx_t    i_sr1;
   reg_idx_t    i_sr2;
   logic        i_pipe_stall;
   reg_idx_t    i_of1_reg;
   reg_idx_t    i_of2_reg;
   logic        i_wb_valid;
   reg_idx_t    i_wb_reg;
   logic        i_kill_valid;
   reg_idx_t    i_kill_reg;

   logic        o_issue_ready;
   logic        o_issue_fire;
   logic        o_hazard_stall;
   logic [14:0] o_busylist;
   logic        o_err;
   logic [31:0] o_stall_cycles;

   modport master (
      output i_issue_valid, i_issue_wr, i_ri, i_dr, i_sr1, i_sr2, i_pipe_stall,
             i_of1_reg, i_of2_reg, i_wb_valid, i_wb_reg, i_kill_valid, i_kill_reg,
      input  o_issue_ready, o_issue_fire, o_hazard_stall, o_busylist, o_err,
             o_stall_cycles
   );

   modport slave (
      input  i_issue_valid, i_issue_wr, i_ri, i_dr, i_sr1, i_sr2, i_pipe_stall,
             i_of1_reg, i_of2_reg, i_wb_valid, i_wb_reg, i_kill_valid, i_kill_reg,
      output o_issue_ready, o_issue_fire, o_hazard_stall, o_busylist, o_err,
             o_stall_cycles
   );
endinterface

// File: rtl/tl45_sb_counter.sv
// One pending-write counter. Increments on issue and decrements on
// writeback and kill; each decrement is dropped when the count is already
// zero, and that attempt is reported on underflow.
module tl45_sb_counter
   import tl45_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      inc,
   input  logic      dec_wb,
   input  logic      dec_kill,
   output pend_cnt_t count,
   output logic      underflow
);
   logic                  wb_ok;
   logic                  kill_ok;
   logic [TL45_CNT_W:0]   count_next;

   // Sum all three terms; decrements only apply to a non-zero count.
   always_comb begin
      wb_ok      = dec_wb   & (count != '0);
      kill_ok    = dec_kill & (count != '0);
      underflow  = (dec_wb | dec_kill) & (count == '0);
      count_next = {1'b0, count}
                 + {{TL45_CNT_W{1'b0}}, inc}
                 - {{TL45_CNT_W{1'b0}}, wb_ok}
                 - {{TL45_CNT_W{1'b0}}, kill_ok};
   end

   // Counter register; inc at max never happens because issue is blocked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else     count <= count_next[TL45_CNT_W-1:0];
   end
endmodule

// File: rtl/tl45_scoreboard.sv
// TL45 register scoreboard: per-register pending counters, issue hazard
// check with forwarding-bus bypass, busy list, sticky underflow error and
// a saturating hazard-stall cycle counter.
module tl45_scoreboard
   import tl45_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   tl45_scoreboard_if.slave   sb
);
   pend_cnt_t             count [0:15];
   logic [TL45_NREGS:1]   underflow;
   logic                  sr1_haz;
   logic                  sr2_haz;
   logic                  dr_haz;
   logic                  ready;
   logic                  fire;
   logic                  stall;
   logic                  err;
   logic [31:0]           stall_cycles;

   // A source is blocked while a write is pending, unless exactly one write
   // is pending and that value is currently on a forwarding bus.
   function automatic logic src_hazard(input reg_idx_t s, input pend_cnt_t c,
                                       input reg_idx_t of1, input reg_idx_t of2);
      if (s == '0)                                   return 1'b0;
      if (c == '0)                                   return 1'b0;
      if (c == pend_cnt_t'(1) && (of1 == s || of2 == s)) return 1'b0;
      return 1'b1;
   endfunction

   // r0 has no counter; it reads as permanently idle.
   assign count[0] = '0;

   generate
      for (genvar gi = 1; gi <= TL45_NREGS; gi++) begin : g_reg
         logic inc;
         logic dec_wb;
         logic dec_kill;

         assign inc      = fire & sb.i_issue_wr & (sb.i_dr == reg_idx_t'(gi));
         assign dec_wb   = sb.i_wb_valid & (sb.i_wb_reg == reg_idx_t'(gi));
         assign dec_kill = sb.i_kill_valid & (sb.i_kill_reg == reg_idx_t'(gi));

         tl45_sb_counter u_cnt (
            .clk       (i_clk),
            .rst       (i_reset),
            .inc       (inc),
            .dec_wb    (dec_wb),
            .dec_kill  (dec_kill),
            .count     (count[gi]),
            .underflow (underflow[gi])
         );

         assign sb.o_busylist[gi-1] = (count[gi] != '0);
      end
   endgenerate

   // Issue decision is purely combinational from the current operands and counters.
   always_comb begin
      sr1_haz = src_hazard(sb.i_sr1, count[sb.i_sr1], sb.i_of1_reg, sb.i_of2_reg);
      sr2_haz = !sb.i_ri &&
                src_hazard(sb.i_sr2, count[sb.i_sr2], sb.i_of1_reg, sb.i_of2_reg);
      dr_haz  = sb.i_issue_wr && (sb.i_dr != '0) && (count[sb.i_dr] == TL45_CNT_MAX);
      ready   = !(sr1_haz || sr2_haz || dr_haz);
      fire    = sb.i_issue_valid & ready & !sb.i_pipe_stall;
      stall   = sb.i_issue_valid & !ready;
   end

   // Sticky error on any release attempt against an empty counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)           err <= 1'b0;
      else if (|underflow)   err <= 1'b1;
   end

   // Hazard-stall cycle counter, saturating at all ones.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                          stall_cycles <= '0;
      else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
   end

   assign sb.o_issue_ready  = ready;
   assign sb.o_issue_fire   = fire;
   assign sb.o_hazard_stall = stall;
   assign sb.o_err          = err;
   assign sb.o_stall_cycles = stall_cycles;
endmodule

// File: tb/tb_tl45_scoreboard.sv
// Scoreboard-style bench for tl45_scoreboard: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops one entry per falling edge
// and compares it against the DUT.
module tb_tl45_scoreboard;
   import tl45_pkg::*;

   typedef struct {
      string       name;
      logic        rdy;
      logic        fire;
      logic        hz;
      logic [14:0] busy;
      logic        err;
      logic [31:0] sc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q [$];
   exp_t mon_e;

   tl45_scoreboard_if bus ();

   tl45_scoreboard dut (
      .i_clk   (clk),
      .i_reset (rst),
      .sb      (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input string fld,
                               input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %0h required %0h", nm, fld, act, req);
      end
   endfunction

   // Monitor: one expected record per cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.name, "ready", 32'(bus.o_issue_ready),  32'(mon_e.rdy));
         chk(mon_e.name, "fire",  32'(bus.o_issue_fire),   32'(mon_e.fire));
         chk(mon_e.name, "stall", 32'(bus.o_hazard_stall), 32'(mon_e.hz));
         chk(mon_e.name, "busy",  32'(bus.o_busylist),     32'(mon_e.busy));
         chk(mon_e.name, "err",   32'(bus.o_err),          32'(mon_e.err));
         chk(mon_e.name, "cycles", bus.o_stall_cycles,     mon_e.sc);
         $display("txn %-14s rdy=%b fire=%b hz=%b busy=%04h err=%b cyc=%0d",
                  mon_e.name, bus.o_issue_ready, bus.o_issue_fire, bus.o_hazard_stall,
                  bus.o_busylist, bus.o_err, bus.o_stall_cycles);
      end
   end

   task automatic drv(input logic v, input logic wr, input logic ri,
                      input logic [3:0] dr, input logic [3:0] sr1, input logic [3:0] sr2,
                      input logic stl, input logic [3:0] of1, input logic [3:0] of2,
                      input logic wbv, input logic [3:0] wbr,
                      input logic kv, input logic [3:0] kr);
      bus.i_issue_valid = v;   bus.i_issue_wr = wr;   bus.i_ri = ri;
      bus.i_dr = dr;           bus.i_sr1 = sr1;       bus.i_sr2 = sr2;
      bus.i_pipe_stall = stl;  bus.i_of1_reg = of1;   bus.i_of2_reg = of2;
      bus.i_wb_valid = wbv;    bus.i_wb_reg = wbr;
      bus.i_kill_valid = kv;   bus.i_kill_reg = kr;
   endtask

   task automatic idle();
      drv(0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0);
   endtask

   task automatic step(input string nm, input logic rdy, input logic fire, input logic hz,
                       input logic [14:0] busy, input logic err, input logic [31:0] sc);
      exp_t e;
      e.name = nm; e.rdy = rdy; e.fire = fire; e.hz = hz;
      e.busy = busy; e.err = err; e.sc = sc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      idle();                                   step("reset",        1,0,0, 15'h0000, 0, 0);
      drv(1,1,0, 3,0,0, 0, 0,0, 0,0, 0,0);      step("issue_r3",     1,1,0, 15'h0000, 0, 0);
      drv(0,0,0, 0,0,0, 0, 0,0, 1,3, 0,0);      step("wb_r3",        1,0,0, 15'h0004, 0, 0);
      idle();                                   step("after_wb3",    1,0,0, 15'h0000, 0, 0);

      drv(1,1,0, 5,0,0, 0, 0,0, 0,0, 0,0);      step("issue_r5",     1,1,0, 15'h0000, 0, 0);
      drv(1,0,0, 0,5,0, 0, 0,0, 0,0, 0,0);      step("haz_r5",       0,0,1, 15'h0010, 0, 0);
      drv(1,0,0, 0,5,0, 0, 0,5, 0,0, 0,0);      step("fwd2_r5",      1,1,0, 15'h0010, 0, 1);
      drv(1,0,0, 0,5,0, 0, 0,0, 1,5, 0,0);      step("wb_no_clear",  0,0,1, 15'h0010, 0, 1);
      idle();                                   step("after_wb5",    1,0,0, 15'h0000, 0, 2);

      drv(1,1,0, 7,0,0, 0, 0,0, 0,0, 0,0);      step("r7_a",         1,1,0, 15'h0000, 0, 2);
      drv(1,1,0, 7,0,0, 0, 0,0, 0,0, 0,0);      step("r7_b",         1,1,0, 15'h0040, 0, 2);
      drv(1,1,0, 7,0,0, 0, 0,0, 0,0, 0,0);      step("r7_c",         1,1,0, 15'h0040, 0, 2);
      drv(1,1,0, 7,0,0, 0, 0,0, 1,7, 0,0);      step("r7_full",      0,0,1, 15'h0040, 0, 2);
      drv(1,1,0, 7,0,0, 0, 0,0, 0,0, 0,0);      step("r7_ready",     1,1,0, 15'h0040, 0, 3);
      drv(1,1,0, 7,0,0, 1, 0,0, 0,0, 0,0);      step("stall_haz",    0,0,1, 15'h0040, 0, 3);
      drv(1,1,0, 8,0,0, 1, 0,0, 0,0, 0,0);      step("stall_nohaz",  1,0,0, 15'h0040, 0, 4);
      drv(0,0,0, 0,0,0, 0, 0,0, 1,7, 1,7);      step("r7_wb_kill",   1,0,0, 15'h0040, 0, 4);
      drv(0,0,0, 0,0,0, 0, 0,0, 1,7, 0,0);      step("r7_last_wb",   1,0,0, 15'h0040, 0, 4);

      drv(1,1,0, 2,0,0, 0, 0,0, 0,0, 0,0);      step("issue_r2",     1,1,0, 15'h0000, 0, 4);
      drv(1,1,0, 2,0,0, 0, 0,0, 1,2, 1,2);      step("r2_triple",    1,1,0, 15'h0002, 0, 4);
      idle();                                   step("r2_clear",     1,0,0, 15'h0000, 0, 4);

      drv(1,1,0, 9,0,0, 0, 0,0, 0,0, 0,0);      step("r9_a",         1,1,0, 15'h0000, 0, 4);
      drv(1,1,0, 9,0,0, 0, 0,0, 0,0, 0,0);      step("r9_b",         1,1,0, 15'h0100, 0, 4);
      drv(1,0,1, 0,0,9, 0, 0,0, 0,0, 0,0);      step("ri_sr2",       1,1,0, 15'h0100, 0, 4);
      drv(1,0,0, 0,0,9, 0, 0,0, 0,0, 0,0);      step("reg_sr2",      0,0,1, 15'h0100, 0, 4);
      drv(1,1,0, 0,0,0, 0, 0,0, 0,0, 0,0);      step("r0_issue",     1,1,0, 15'h0100, 0, 5);
      drv(0,0,0, 0,0,0, 0, 0,0, 1,0, 0,0);      step("r0_release",   1,0,0, 15'h0100, 0, 5);
      drv(0,0,0, 0,0,0, 0, 0,0, 1,4, 0,0);      step("wb_r4_empty",  1,0,0, 15'h0100, 0, 5);
      idle();                                   step("err_set",      1,0,0, 15'h0100, 1, 5);
      idle();                                   step("err_sticky",   1,0,0, 15'h0100, 1, 5);

      rst = 1'b1;                               step("mid_reset",    1,0,0, 15'h0000, 0, 0);
      rst = 1'b0;                               step("post_reset",   1,0,0, 15'h0000, 0, 0);

      drv(1,1,0, 6,0,0, 0, 0,0, 0,0, 0,0);      step("issue_r6",     1,1,0, 15'h0000, 0, 0);
      for (int i = 0; i < 10; i++) begin
         drv(1,0,0, 0,6,0, 0, 0,0, 0,0, 0,0);   step("hold_haz",     0,0,1, 15'h0020, 0, 32'(i));
      end
      idle();                                   step("ten_stalls",   1,0,0, 15'h0020, 0, 10);
      rst = 1'b1;                               step("reset_pend",   1,0,0, 15'h0000, 0, 0);
      rst = 1'b0;                               step("final_idle",   1,0,0, 15'h0000, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
